// File: rtl/load_store_unit.sv
// Load/store unit: splits RV32I loads/stores into little-endian byte transactions
// on a byte-wide memory port and returns one extended response per request.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t             state_q;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   last_q;
  logic [DATA_W-1:0]  buf_q;

  logic               f3_ok;
  logic               misaligned;
  logic               req_legal;
  logic [IDX_W-1:0]   last_d;
  logic [DATA_W-1:0]  buf_d;
  logic [IDX_W-1:0]   idx_nx;
  logic [ADDR_W-1:0]  addr_nx;
  logic [BYTE_W-1:0]  wbyte_nx;
  logic [DATA_W-1:0]  load_ext;

  assign req_ready = (state_q == IDLE);

  // Request legality and transfer length decode
  always_comb begin
    if (req_we) begin
      f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_legal  = f3_ok && !misaligned;
    case (req_funct3[1:0])
      2'b01:   last_d = 2'd1;
      2'b10:   last_d = 2'd3;
      default: last_d = 2'd0;
    endcase
  end

  // Assembly buffer including the byte arriving this cycle, plus next-byte address/data
  always_comb begin
    buf_d = buf_q;
    buf_d[{idx_q, 3'b000} +: BYTE_W] = m_rdata;
    idx_nx   = idx_q + 2'd1;
    addr_nx  = addr_q + ADDR_W'(idx_nx);
    wbyte_nx = wdata_q[{idx_nx, 3'b000} +: BYTE_W];
    case (funct3_q)
      3'b000:  load_ext = {{24{buf_d[7]}}, buf_d[7:0]};
      3'b100:  load_ext = {24'd0, buf_d[7:0]};
      3'b001:  load_ext = {{16{buf_d[15]}}, buf_d[15:0]};
      3'b101:  load_ext = {16'd0, buf_d[15:0]};
      3'b010:  load_ext = buf_d;
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      buf_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_legal) begin
              state_q  <= XFER;
              we_q     <= req_we;
              funct3_q <= req_funct3;
              addr_q   <= req_addr;
              wdata_q  <= req_wdata;
              idx_q    <= '0;
              last_q   <= last_d;
              buf_q    <= '0;
              m_en     <= 1'b1;
              m_we     <= req_we;
              m_addr   <= req_addr;
              m_wdata  <= req_wdata[7:0];
            end else begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        XFER: begin
          if (!we_q) begin
            buf_q <= buf_d;
          end
          if (idx_q == last_q) begin
            state_q   <= RESP;
            m_en      <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_q ? '0 : load_ext;
          end else begin
            idx_q   <= idx_nx;
            m_addr  <= addr_nx;
            m_wdata <= wbyte_nx;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected byte transactions and responses are
// queued at issue time and checked by negedge monitors, including exact cycle numbers.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_wdata;
  logic [7:0]        m_rdata;

  logic [7:0] mem [256];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
    int          cyc;
  } mtx_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  rsp_t rsp_q[$];
  mtx_t mtx_q[$];

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .m_en       (m_en),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata)
  );

  always #5 clk = ~clk;

  assign m_rdata = mem[m_addr[7:0]];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr[7:0]] <= m_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    rsp_t r;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(r.err));
        chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
      end
    end
  end

  // Memory-port monitor
  always @(negedge clk) begin
    mtx_t t;
    if (m_en) begin
      chk("ready_in_xfer", 32'(req_ready), 32'd0);
      if (mtx_q.size() == 0) begin
        chk("unexpected_m_en", 32'(m_en), 32'd0);
      end else begin
        t = mtx_q.pop_front();
        chk("m_we", 32'(m_we), 32'(t.we));
        chk("m_addr", m_addr, t.addr);
        chk("m_wdata", 32'(m_wdata), 32'(t.wdata));
        chk("m_cycle", 32'(cyc), 32'(t.cyc));
      end
    end
  end

  // Drive one request starting at a negedge; returns the acceptance edge number k.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata_exp,
                       input logic err_exp, input bit hold, input bit abort,
                       output int k);
    int   n;
    bit   ready_seen;
    rsp_t r;
    mtx_t t;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    ready_seen = 1'b0;
    for (int w = 0; w < 50; w++) begin
      if (req_ready) begin
        ready_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ready_seen) chk("accept_timeout", 32'(req_ready), 32'd1);
    k = cyc + 1;
    if (err_exp) begin
      r = '{rdata: 32'd0, err: 1'b1, cyc: k};
      rsp_q.push_back(r);
    end else begin
      for (int i = 0; i < (abort ? 3 : n); i++) begin
        t = '{we: we, addr: addr + 32'(i), wdata: wdata[8*i +: 8], cyc: k + i};
        mtx_q.push_back(t);
      end
      if (!abort) begin
        r = '{rdata: rdata_exp, err: 1'b0, cyc: k + n};
        rsp_q.push_back(r);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int w = 0; w < 60; w++) begin
      if (rsp_q.size() == 0 && mtx_q.size() == 0 && req_ready) break;
      @(negedge clk);
    end
    chk("drain", 32'(rsp_q.size() + mtx_q.size()), 32'd0);
    @(negedge clk);
  endtask

  vec_t vecs[10];
  int   k0, k1, k2;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h21; mem[8'h11] = 8'h43; mem[8'h12] = 8'h65; mem[8'h13] = 8'h87;
    mem[8'h52] = 8'h5A; mem[8'h53] = 8'hA5;

    vecs[0] = '{1'b0, 3'b010, 32'h10, 32'h0,         32'h8765_4321, 1'b0};
    vecs[1] = '{1'b0, 3'b000, 32'h13, 32'h0,         32'hFFFF_FF87, 1'b0};
    vecs[2] = '{1'b0, 3'b100, 32'h13, 32'h0,         32'h0000_0087, 1'b0};
    vecs[3] = '{1'b0, 3'b001, 32'h12, 32'h0,         32'hFFFF_8765, 1'b0};
    vecs[4] = '{1'b0, 3'b101, 32'h12, 32'h0,         32'h0000_8765, 1'b0};
    vecs[5] = '{1'b0, 3'b000, 32'h10, 32'h0,         32'h0000_0021, 1'b0};
    vecs[6] = '{1'b1, 3'b001, 32'h22, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[7] = '{1'b0, 3'b010, 32'h21, 32'h0,         32'h0,         1'b1};
    vecs[8] = '{1'b1, 3'b001, 32'h31, 32'hDEAD_BEEF, 32'h0,         1'b1};
    vecs[9] = '{1'b0, 3'b011, 32'h40, 32'h0,         32'h0,         1'b1};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", 32'(m_wdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
            vecs[i].err, 1'b0, 1'b0, k0);
    end
    issue(1'b1, 3'b100, 32'h40, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 1'b0, k0);
    wait_idle();
    chk("sh_byte0", 32'(mem[8'h22]), 32'h0000_00EF);
    chk("sh_byte1", 32'(mem[8'h23]), 32'h0000_00BE);
    chk("sh_no_spill", 32'(mem[8'h24]), 32'h0000_0000);

    // Store aborted by reset during its third byte
    issue(1'b1, 3'b010, 32'h50, 32'h1122_3344, 32'h0, 1'b0, 1'b0, 1'b1, k0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("abort_m_en", 32'(m_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    wait_idle();
    chk("abort_byte0", 32'(mem[8'h50]), 32'h0000_0044);
    chk("abort_byte1", 32'(mem[8'h51]), 32'h0000_0033);
    chk("abort_byte2", 32'(mem[8'h52]), 32'h0000_005A);
    chk("abort_byte3", 32'(mem[8'h53]), 32'h0000_00A5);
    issue(1'b0, 3'b010, 32'h50, 32'h0, 32'hA55A_3344, 1'b0, 1'b0, 1'b0, k0);
    wait_idle();

    // Back-to-back with req_valid held high
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8765_4321, 1'b0, 1'b1, 1'b0, k1);
    issue(1'b1, 3'b000, 32'h60, 32'h0000_00AA, 32'h0, 1'b0, 1'b0, 1'b0, k2);
    chk("b2b_accept_edge", 32'(k2), 32'(k1 + 6));
    wait_idle();
    chk("sb_byte", 32'(mem[8'h60]), 32'h0000_00AA);
    chk("sb_no_spill", 32'(mem[8'h61]), 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store unit between the RISC-V core datapath and a byte-wide, byte-addressable data memory port. It accepts one load or store request at a time over a valid/ready handshake and checks alignment and funct3. It then issues the access as a sequence of single-byte memory transactions in little-endian order. Loads are reassembled and sign- or zero-extended per RV32I funct3, and every request ends with a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 32, width of the request and memory addresses.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; high exactly when the state is IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low bytes are used for SB/SH.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors. Holds its value until the next response.
- rsp_err  out  1  request rejected (misaligned or illegal funct3); qualified by rsp_valid.
- m_en  out  1  memory byte transaction this cycle.
- m_we  out  1  byte write when m_en = 1.
- m_addr  out  ADDR_W  byte address of the current transaction.
- m_wdata  out  8  byte to write.
- m_rdata  in  8  read byte; combinational, valid in the same cycle as m_en / m_addr.

## Operation
- States:
  - IDLE: req_ready = 1.
  - XFER: one byte per cycle.
  - RESP: rsp_valid = 1 for exactly one cycle.
- IDLE to XFER: on an edge with req_valid & req_ready and a legal request.
  - Latch we, funct3, addr, wdata.
  - Set byte index idx = 0.
  - Set N = 1, 2 or 4 bytes for size 00, 01 or 10 (funct3[1:0]).
- IDLE to RESP with rsp_err = 1 and no memory activity, for any of:
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - LH/LHU/SH with addr[0] = 1.
  - LW/SW with addr[1:0] ≠ 00.
- XFER, each cycle:
  - m_en = 1, m_we = latched we, m_addr = base + idx (ADDR_W-bit modulo add), m_wdata = wdata byte idx.
  - Loads capture m_rdata into byte idx of the assembly buffer at the edge.
  - idx increments each cycle. When idx = N−1, the next state is RESP.
- RESP result by funct3:
  - LB: sign-extend byte 0.
  - LBU: zero-extend byte 0.
  - LH: sign-extend bits [15:0].
  - LHU: zero-extend bits [15:0].
  - LW: all 32 bits.
  - Stores: 0, rsp_err = 0.
- RESP to IDLE unconditionally.
- Outside XFER, m_en, m_we, m_addr and m_wdata are 0.
- req_* inputs are ignored outside IDLE; the latched copy is used for the whole transaction.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE; idx, N and the buffer are cleared.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - m_en = 0, m_we = 0, m_addr = 0, m_wdata = 0.
  - req_ready follows the state (1). Requests on edges while reset is asserted are not accepted.
- Legal request accepted at edge k:
  - m_en is high in cycles k+1 .. k+N.
  - rsp_valid is high in cycle k+N+1.
  - req_ready is high again in cycle k+N+2.
  - Latency: LB/SB 2 cycles, LH/SH 3 cycles, LW/SW 5 cycles from acceptance edge to response.
- Error request accepted at edge k: rsp_valid in cycle k+1, req_ready again in cycle k+2.
- Reset mid-XFER: the transaction is aborted. m_en drops in the same cycle, no response is issued, and partially written bytes remain in memory.
- Back-to-back: with req_valid held high, the next request is accepted at the first edge where req_ready = 1. There is no overlap with RESP.
- Aligned legal accesses never wrap a word boundary. m_addr arithmetic is modulo 2^ADDR_W.

## Test plan
- LW at 0x10, memory bytes 0x21, 0x43, 0x65, 0x87 at 0x10..0x13:
  - m_addr 0x10, 0x11, 0x12, 0x13 with m_en = 1, m_we = 0 in cycles k+1..k+4.
  - rsp_valid in cycle k+5 with rsp_rdata = 0x8765_4321, rsp_err = 0.
- Same memory:
  - LB 0x13 -> 0xFFFF_FF87.
  - LBU 0x13 -> 0x0000_0087.
  - LH 0x12 -> 0xFFFF_8765.
  - LHU 0x12 -> 0x0000_8765.
  - LB 0x10 -> 0x0000_0021.
- SH 0xDEAD_BEEF at 0x22:
  - Exactly two writes: 0xEF to 0x22, then 0xBE to 0x23.
  - rsp_valid in cycle k+3 with rsp_rdata = 0, rsp_err = 0.
- Error requests: LW at 0x21, SH at 0x31, and load funct3 = 011 at 0x40:
  - m_en never asserts.
  - rsp_valid with rsp_err = 1 in cycle k+1 and rsp_rdata = 0.
- SW 0x1122_3344 at 0x50 with reset pulsed during the third byte:
  - m_en drops immediately and no rsp_valid follows.
  - Bytes 0x44 and 0x33 are written; 0x52 and 0x53 are unchanged.
  - A subsequent LW 0x50 completes normally.
- req_valid held high with LW 0x10 then SB 0xAA at 0x60:
  - The second request is accepted only at the edge ending cycle k+6.
  - A single write of 0xAA to 0x60 follows.
